// File: rtl/tm_master_rob_credit_if.sv
// Handshake bundle between the master module, the packetizer/depacketizer
// pair and the tag allocator / reorder buffer.
interface tm_master_rob_credit_if #(
    parameter int WIDTH_TAG     = 3,
    parameter int WIDTH_DATA_IN = 36
);
    // Request side
    logic                     send_valid_in;
    logic                     send_ready_in;
    logic                     send_ready_out;
    logic                     send_valid_out;
    logic [WIDTH_TAG-1:0]     send_tag;
    // Response side
    logic                     receive_valid_in;
    logic [WIDTH_TAG-1:0]     receive_tag;
    logic [WIDTH_DATA_IN-1:0] receive_data_in;
    logic                     receive_ready_out;
    logic                     receive_valid_out;
    logic [WIDTH_DATA_IN-1:0] receive_data_out;
    logic                     receive_ready_in;
    // Status
    logic [WIDTH_TAG:0]       outstanding;
    logic                     resp_err;

    // Seen from the reorder buffer itself
    modport slave (
        input  send_valid_in, send_ready_in,
        input  receive_valid_in, receive_tag, receive_data_in, receive_ready_in,
        output send_ready_out, send_valid_out, send_tag,
        output receive_ready_out, receive_valid_out, receive_data_out,
        output outstanding, resp_err
    );

    // Seen from the surrounding logic driving the reorder buffer
    modport master (
        output send_valid_in, send_ready_in,
        output receive_valid_in, receive_tag, receive_data_in, receive_ready_in,
        input  send_ready_out, send_valid_out, send_tag,
        input  receive_ready_out, receive_valid_out, receive_data_out,
        input  outstanding, resp_err
    );
endinterface

// File: rtl/tm_master_rob_credit.sv
// Master-side tag allocator and reorder buffer. Requests get sequential tags
// (the tag pool doubles as the credit pool); out-of-order responses are parked
// per tag and released to the master strictly in issue order.
module tm_master_rob_credit #(
    parameter int NUM_TAGS      = 8,
    parameter int WIDTH_TAG     = 3,
    parameter int WIDTH_DATA_IN = 36
) (
    input  logic clk,
    input  logic preset_full,
    tm_master_rob_credit_if.slave bus
);
    localparam logic [WIDTH_TAG:0] FULL_COUNT = (WIDTH_TAG+1)'(NUM_TAGS);

    logic [WIDTH_TAG-1:0]     head_reg;
    logic [WIDTH_TAG-1:0]     tail_reg;
    logic [WIDTH_TAG:0]       count_reg;
    logic [NUM_TAGS-1:0]      valid_reg;
    logic [NUM_TAGS-1:0]      valid_next;
    logic                     resp_err_reg;
    logic [WIDTH_DATA_IN-1:0] mem [NUM_TAGS];

    logic                     not_full;
    logic                     issue;
    logic                     pop;
    logic [WIDTH_TAG-1:0]     resp_dist;
    logic                     resp_legal;
    logic                     resp_write;
    logic                     resp_bad;

    // A tag is writable only if it lies inside the allocated window
    // [head, head+count) and has not already been answered. The window test
    // uses modular distance so it stays correct across the tag wrap.
    assign not_full   = (count_reg < FULL_COUNT);
    assign issue      = bus.send_valid_in & bus.send_ready_in & not_full & ~preset_full;
    assign pop        = valid_reg[head_reg] & bus.receive_ready_in;
    assign resp_dist  = bus.receive_tag - head_reg;
    assign resp_legal = ({1'b0, resp_dist} < count_reg) & ~valid_reg[bus.receive_tag];
    assign resp_write = bus.receive_valid_in & resp_legal;
    assign resp_bad   = bus.receive_valid_in & ~resp_legal & ~preset_full;

    // Outputs are forced low while reset is held so nothing leaks out mid-reset.
    assign bus.send_ready_out    = bus.send_ready_in & not_full & ~preset_full;
    assign bus.send_valid_out    = bus.send_valid_in & not_full & ~preset_full;
    assign bus.send_tag          = tail_reg;
    assign bus.receive_ready_out = ~preset_full;
    assign bus.receive_valid_out = valid_reg[head_reg];
    assign bus.receive_data_out  = preset_full ? '0 : mem[head_reg];
    assign bus.outstanding       = count_reg;
    assign bus.resp_err          = resp_err_reg;

    // Per-tag valid bit: set by a legal response, cleared when that tag pops.
    // A write and a pop never target the same tag in one cycle.
    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_valid
            assign valid_next[gi] =
                (resp_write && (bus.receive_tag == WIDTH_TAG'(gi))) ? 1'b1 :
                (pop && (head_reg == WIDTH_TAG'(gi)))               ? 1'b0 :
                valid_reg[gi];
        end
    endgenerate

    // Valid bits register
    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) valid_reg <= '0;
        else             valid_reg <= valid_next;
    end

    // Payload storage, written only by legal responses; no reset needed
    always_ff @(posedge clk) begin
        if (resp_write) mem[bus.receive_tag] <= bus.receive_data_in;
    end

    // Head/tail pointers, credit count and sticky error flag
    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            resp_err_reg <= 1'b0;
        end else begin
            if (issue) tail_reg <= tail_reg + 1'b1;
            if (pop)   head_reg <= head_reg + 1'b1;
            case ({issue, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (resp_bad) resp_err_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tm_master_rob_credit.sv
// Directed bench for tm_master_rob_credit. Stimulus pushes expected in-order
// payloads into a queue; a monitor pops and compares on every DUT pop.
module tb_tm_master_rob_credit;
    localparam int NT = 8;
    localparam int WT = 3;
    localparam int WD = 36;

    logic clk = 1'b0;
    logic preset_full;
    int   checks = 0;
    int   errors = 0;
    logic [WD-1:0] exp_q[$];

    tm_master_rob_credit_if #(.WIDTH_TAG(WT), .WIDTH_DATA_IN(WD)) bus();

    tm_master_rob_credit #(.NUM_TAGS(NT), .WIDTH_TAG(WT), .WIDTH_DATA_IN(WD)) dut (
        .clk         (clk),
        .preset_full (preset_full),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted in-order response must match the queue head
    always @(negedge clk) begin
        if (!preset_full && bus.receive_valid_out && bus.receive_ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.receive_data_out);
            end else begin
                logic [WD-1:0] e;
                e = exp_q.pop_front();
                if (bus.receive_data_out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", bus.receive_data_out, e);
                end else begin
                    $display("pop  data %0h", bus.receive_data_out);
                end
            end
        end
    end

    task automatic issue(input int n, input int first_tag);
        for (int i = 0; i < n; i++) begin
            bus.send_valid_in = 1'b1;
            bus.send_ready_in = 1'b1;
            #1;
            chk("send_tag", bus.send_tag, 64'((first_tag + i) % NT));
            chk("send_ready_out", bus.send_ready_out, 1);
            tick();
        end
        bus.send_valid_in = 1'b0;
        bus.send_ready_in = 1'b0;
    endtask

    task automatic respond(input logic [WT-1:0] tag, input logic [WD-1:0] data);
        bus.receive_valid_in = 1'b1;
        bus.receive_tag      = tag;
        bus.receive_data_in  = data;
        tick();
        bus.receive_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        bus.send_valid_in = 1'b1;
        bus.send_ready_in = 1'b1;
        preset_full = 1'b1;
        #2;
        chk("rst_send_ready_out", bus.send_ready_out, 0);
        chk("rst_send_valid_out", bus.send_valid_out, 0);
        chk("rst_receive_ready_out", bus.receive_ready_out, 0);
        chk("rst_receive_valid_out", bus.receive_valid_out, 0);
        chk("rst_receive_data_out", bus.receive_data_out, 0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_send_tag", bus.send_tag, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        bus.send_valid_in = 1'b0;
        bus.send_ready_in = 1'b0;
        preset_full = 1'b0;
        #1;
        chk("post_rst_outstanding", bus.outstanding, 0);
        chk("post_rst_send_tag", bus.send_tag, 0);
        chk("post_rst_receive_ready_out", bus.receive_ready_out, 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset_full          = 1'b1;
        bus.send_valid_in    = 1'b0;
        bus.send_ready_in    = 1'b0;
        bus.receive_valid_in = 1'b0;
        bus.receive_tag      = '0;
        bus.receive_data_in  = '0;
        bus.receive_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_outstanding", bus.outstanding, 0);
        chk("init_receive_ready_out", bus.receive_ready_out, 0);
        chk("init_receive_valid_out", bus.receive_valid_out, 0);
        preset_full = 1'b0;
        #1;
        chk("init_receive_ready_out_rel", bus.receive_ready_out, 1);
        tick();

        // 1: reset mid-cycle with 3 outstanding, then a late response
        issue(3, 0);
        chk("t1_outstanding", bus.outstanding, 3);
        do_reset();
        respond(3'd1, 36'h99);
        chk("t1_late_resp_err", bus.resp_err, 1);
        chk("t1_late_outstanding", bus.outstanding, 0);
        do_reset();

        // 2: out-of-order responses released in issue order
        issue(4, 0);
        exp_q.push_back(36'hA0);
        exp_q.push_back(36'hA1);
        exp_q.push_back(36'hA2);
        exp_q.push_back(36'hA3);
        bus.receive_ready_in = 1'b1;
        respond(3'd2, 36'hA2);
        chk("t2_valid_before_head", bus.receive_valid_out, 0);
        respond(3'd0, 36'hA0);
        chk("t2_head_latency_valid", bus.receive_valid_out, 1);
        chk("t2_head_latency_data", bus.receive_data_out, 36'hA0);
        respond(3'd3, 36'hA3);
        chk("t2_valid_gap", bus.receive_valid_out, 0);
        respond(3'd1, 36'hA1);
        repeat (4) tick();
        chk("t2_outstanding", bus.outstanding, 0);
        chk("t2_queue_drained", exp_q.size(), 0);
        do_reset();

        // 3: fill all tags, full stalls, then wrap to tag 0
        issue(8, 0);
        bus.send_valid_in = 1'b1;
        bus.send_ready_in = 1'b1;
        #1;
        chk("t3_full_outstanding", bus.outstanding, 8);
        chk("t3_full_send_ready_out", bus.send_ready_out, 0);
        chk("t3_full_send_valid_out", bus.send_valid_out, 0);
        bus.send_valid_in = 1'b0;
        bus.send_ready_in = 1'b0;
        exp_q.push_back(36'h30);
        bus.receive_ready_in = 1'b1;
        respond(3'd0, 36'h30);
        tick();
        chk("t3_after_pop_outstanding", bus.outstanding, 7);
        chk("t3_wrap_send_tag", bus.send_tag, 0);
        issue(1, 0);
        chk("t3_refill_outstanding", bus.outstanding, 8);

        // 4: head response held under backpressure for 5 cycles
        bus.receive_ready_in = 1'b0;
        respond(3'd1, 36'h44);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", bus.receive_valid_out, 1);
            chk("t4_hold_data", bus.receive_data_out, 36'h44);
            tick();
        end
        exp_q.push_back(36'h44);
        bus.receive_ready_in = 1'b1;
        tick();
        chk("t4_outstanding", bus.outstanding, 7);
        chk("t4_next_valid", bus.receive_valid_out, 0);
        chk("t4_send_tag", bus.send_tag, 1);
        do_reset();

        // 5: unallocated and duplicate responses are dropped and flagged
        chk("t5_err_clear", bus.resp_err, 0);
        issue(2, 0);
        bus.receive_ready_in = 1'b1;
        respond(3'd5, 36'h55);
        chk("t5_unalloc_err", bus.resp_err, 1);
        chk("t5_unalloc_outstanding", bus.outstanding, 2);
        chk("t5_unalloc_valid", bus.receive_valid_out, 0);
        exp_q.push_back(36'h50);
        respond(3'd0, 36'h50);
        chk("t5_tag0_valid", bus.receive_valid_out, 1);
        respond(3'd0, 36'h51);
        chk("t5_dup_outstanding", bus.outstanding, 1);
        chk("t5_dup_valid", bus.receive_valid_out, 0);
        chk("t5_dup_err", bus.resp_err, 1);
        exp_q.push_back(36'h52);
        respond(3'd1, 36'h52);
        tick();
        chk("t5_outstanding", bus.outstanding, 0);
        chk("t5_queue_drained", exp_q.size(), 0);
        do_reset();

        // 6: simultaneous issue and pop keeps the count, advances both ends
        issue(3, 0);
        bus.receive_ready_in = 1'b0;
        respond(3'd0, 36'h60);
        chk("t6_outstanding_before", bus.outstanding, 3);
        exp_q.push_back(36'h60);
        bus.receive_ready_in = 1'b1;
        bus.send_valid_in    = 1'b1;
        bus.send_ready_in    = 1'b1;
        #1;
        chk("t6_send_tag", bus.send_tag, 3);
        chk("t6_send_ready_out", bus.send_ready_out, 1);
        tick();
        bus.send_valid_in = 1'b0;
        bus.send_ready_in = 1'b0;
        chk("t6_outstanding_after", bus.outstanding, 3);
        chk("t6_tail", bus.send_tag, 4);
        chk("t6_head_not_valid", bus.receive_valid_out, 0);
        exp_q.push_back(36'h61);
        respond(3'd1, 36'h61);
        chk("t6_head1_valid", bus.receive_valid_out, 1);
        chk("t6_head1_data", bus.receive_data_out, 36'h61);
        tick();
        chk("t6_final_outstanding", bus.outstanding, 2);
        chk("t6_resp_err", bus.resp_err, 0);
        chk("t6_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
